// File: rtl/moo_blk_seq.sv
// moo_blk_seq
// Block sequencer for the mode-of-operation core. Loads the message length
// into the size buffer, then processes the message one block at a time:
// pop an input block, start the cipher engine, wait for its completion,
// write the output block and consume one block from the size buffer.
// Signals completion once the remaining size reaches zero.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   clr_core             synchronous abort, highest priority
//   start                one-cycle request to process a message
//   busy                 FSM is not idle
//   done                 one-cycle pulse on normal completion
//   remain_up            load size buffer with the message size
//   remain_nxt           consume one block in the size buffer
//   remain_size          remaining bytes from the size buffer
//   msg_lst / msg_done   remain_size < 17 / remain_size == 0
//   din_vld / din_rd     input FIFO block available / pop
//   core_start/core_done cipher engine handshake
//   dout_rdy / dout_wr   output buffer ready / write
//   blk_bytes, blk_mask  valid bytes and byte mask of the current block
//   blk_cnt              blocks completed since the last start
module moo_blk_seq #(
    parameter int BLK_BYTES = 16,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_core,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             remain_up,
    output logic             remain_nxt,
    input  logic [31:0]      remain_size,
    input  logic             msg_lst,
    input  logic             msg_done,
    input  logic             din_vld,
    output logic             din_rd,
    output logic             core_start,
    input  logic             core_done,
    input  logic             dout_rdy,
    output logic             dout_wr,
    output logic [4:0]       blk_bytes,
    output logic [15:0]      blk_mask,
    output logic [CNT_W-1:0] blk_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHK,
        S_WAIT_IN,
        S_RUN,
        S_WAIT_OUT,
        S_FIN
    } state_t;

    state_t            state_q;
    logic [4:0]        bytes_q;
    logic [4:0]        bytes_d;
    logic [15:0]       mask_q;
    logic [15:0]       mask_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              rd_fire;
    logic              wr_fire;

    // Only the low five bits carry the tail length of the last block.
    logic              unused_size_hi;
    assign unused_size_hi = ^remain_size[31:5];

    // Handshake pulses are Mealy so that a block is taken in the same
    // cycle its valid/ready is seen; clr_core suppresses every pulse.
    assign rd_fire    = (state_q == S_WAIT_IN)  && din_vld  && !clr_core;
    assign wr_fire    = (state_q == S_WAIT_OUT) && dout_rdy && !clr_core;
    assign din_rd     = rd_fire;
    assign core_start = rd_fire;
    assign dout_wr    = wr_fire;
    assign remain_nxt = wr_fire;
    assign remain_up  = (state_q == S_LOAD) && !clr_core;
    assign done       = (state_q == S_FIN)  && !clr_core;
    assign busy       = (state_q != S_IDLE);

    assign blk_bytes  = bytes_q;
    assign blk_mask   = mask_q;
    assign blk_cnt    = cnt_q;

    always_comb begin
        bytes_d = msg_lst ? remain_size[4:0] : 5'(BLK_BYTES);
        mask_d  = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            mask_d[i] = (i < 32'(bytes_d));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            bytes_q <= '0;
            mask_q  <= '0;
            cnt_q   <= '0;
        end else if (clr_core) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_LOAD;
                        cnt_q   <= '0;
                    end
                end
                S_LOAD: state_q <= S_CHK;
                S_CHK: begin
                    // Size buffer has absorbed the previous load/consume here.
                    state_q <= msg_done ? S_FIN : S_WAIT_IN;
                end
                S_WAIT_IN: begin
                    if (din_vld) begin
                        bytes_q <= bytes_d;
                        mask_q  <= mask_d;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (core_done) state_q <= S_WAIT_OUT;
                end
                S_WAIT_OUT: begin
                    if (dout_rdy) begin
                        cnt_q   <= cnt_q + CNT_W'(1);
                        state_q <= S_CHK;
                    end
                end
                S_FIN:   state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_moo_blk_seq.sv
module tb_moo_blk_seq;

    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clr_core = 1'b0;
    logic          start = 1'b0;
    logic          din_vld = 1'b0;
    logic          core_done = 1'b0;
    logic          dout_rdy = 1'b0;
    logic          busy, done, remain_up, remain_nxt, din_rd, core_start, dout_wr;
    logic [4:0]    blk_bytes;
    logic [15:0]   blk_mask;
    logic [CW-1:0] blk_cnt;
    logic [31:0]   remain_size;
    logic          msg_lst, msg_done;
    logic [31:0]   size_in = '0;

    always #5 clk = ~clk;

    moo_blk_seq #(.BLK_BYTES(16), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .clr_core(clr_core), .start(start),
        .busy(busy), .done(done), .remain_up(remain_up), .remain_nxt(remain_nxt),
        .remain_size(remain_size), .msg_lst(msg_lst), .msg_done(msg_done),
        .din_vld(din_vld), .din_rd(din_rd), .core_start(core_start),
        .core_done(core_done), .dout_rdy(dout_rdy), .dout_wr(dout_wr),
        .blk_bytes(blk_bytes), .blk_mask(blk_mask), .blk_cnt(blk_cnt)
    );

    // Size buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          remain_size <= '0;
        else if (remain_up)  remain_size <= size_in;
        else if (remain_nxt) remain_size <= msg_lst ? 32'd0 : remain_size - 32'd16;
    end
    assign msg_lst  = (remain_size < 32'd17);
    assign msg_done = (remain_size == 32'd0);

    int tests = 0;
    int fails = 0;

    // Cycle counter and cipher engine: done arrives core_lat cycles after start.
    int   cyc = 0;
    int   core_due = -1;
    int   core_lat = 4;
    logic spur_core = 1'b0;
    always begin
        @(posedge clk);
        #1;
        cyc++;
        core_done = (cyc == core_due) || spur_core;
    end
    always @(negedge clk) if (core_start === 1'b1) core_due = cyc + core_lat;

    // Monitor
    int n_rd, n_cs, n_wr, n_nxt, n_up, n_done, pair_err;
    int up_cyc, done_cyc, first_rd, first_wr;
    int obs_bytes[$];
    int obs_mask[$];
    always @(negedge clk) begin
        if (din_rd === 1'b1) begin n_rd++; if (first_rd < 0) first_rd = cyc; end
        if (core_start === 1'b1) n_cs++;
        if (dout_wr === 1'b1) begin
            n_wr++;
            if (first_wr < 0) first_wr = cyc;
            obs_bytes.push_back(int'(blk_bytes));
            obs_mask.push_back(int'(blk_mask));
        end
        if (remain_nxt === 1'b1) n_nxt++;
        if (remain_up === 1'b1) begin n_up++; up_cyc = cyc; end
        if (done === 1'b1) begin n_done++; done_cyc = cyc; end
        if (din_rd !== core_start) pair_err++;
        if (dout_wr !== remain_nxt) pair_err++;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic clear_mon();
        n_rd = 0; n_cs = 0; n_wr = 0; n_nxt = 0; n_up = 0; n_done = 0; pair_err = 0;
        up_cyc = -1; done_cyc = -1; first_rd = -1; first_wr = -1;
        obs_bytes.delete();
        obs_mask.delete();
    endtask

    // Reference: block count, block size and mask from the message length.
    function automatic int ref_blocks(input int size);
        return (size + 15) / 16;
    endfunction
    function automatic int ref_bytes(input int size, input int idx);
        int n = ref_blocks(size);
        return (idx < n - 1) ? 16 : size - 16 * (n - 1);
    endfunction
    function automatic int ref_mask(input int b);
        return (1 << b) - 1;
    endfunction
    // done cycle offset from the start cycle under the bench's ready policy
    function automatic int ref_done_off(input int size, input int lat,
                                        input int din_hold, input int dout_hold);
        int extra = (din_hold > 3) ? din_hold - 3 : 0;
        return 3 + ref_blocks(size) * (lat + 3 + dout_hold) + extra;
    endfunction

    // Drives one message to completion plus slack. din_vld rises din_hold
    // cycles after start; dout_rdy stays low dout_hold cycles after each
    // core_done. Optional spurious core_done / repeated start at given offsets.
    task automatic run_msg(input int size, input int lat, input int din_hold,
                           input int dout_hold, input int spur_at,
                           input int restart_at, output int s);
        int budget;
        int off;
        int last_cd = -1000;
        clear_mon();
        core_lat = lat;
        size_in  = 32'(size);
        budget   = 10 + ref_blocks(size) * (lat + 4 + dout_hold) + din_hold;
        s        = cyc;
        start    = 1'b1;
        din_vld  = (din_hold == 0);
        dout_rdy = 1'b1;
        for (int k = 0; k < budget; k++) begin
            step(1);
            off       = cyc - s;
            start     = (off == restart_at);
            spur_core = (off + 1 == spur_at);
            din_vld   = (off >= din_hold);
            if (core_done) last_cd = cyc;
            dout_rdy  = (dout_hold == 0) || ((cyc - last_cd) > dout_hold);
        end
        start = 1'b0; spur_core = 1'b0; din_vld = 1'b0; dout_rdy = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(3);
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
        tests++;
        if ({done, remain_up, remain_nxt, din_rd, core_start, dout_wr} !== 6'b0) begin
            fails++;
            $display("FAIL reset_pulses: got %b expected 000000",
                     {done, remain_up, remain_nxt, din_rd, core_start, dout_wr});
        end
        tests++;
        if ({blk_bytes, blk_mask, blk_cnt} !== '0) begin
            fails++;
            $display("FAIL reset_regs: bytes %0d mask %h cnt %0d expected all 0",
                     blk_bytes, blk_mask, blk_cnt);
        end
        rst_n = 1'b1;
        step(2);
    endtask

    task automatic test_zero();
        int s;
        run_msg(0, 4, 0, 0, -1, -1, s);
        tests++;
        if (up_cyc - s !== 1) begin fails++; $display("FAIL zero_up_cycle: got %0d expected 1", up_cyc - s); end
        tests++;
        if (done_cyc - s !== 3 || n_done !== 1) begin
            fails++; $display("FAIL zero_done: cycle %0d count %0d expected cycle 3 count 1", done_cyc - s, n_done);
        end
        tests++;
        if (n_rd + n_cs + n_wr !== 0) begin
            fails++; $display("FAIL zero_no_blocks: rd %0d cs %0d wr %0d expected 0", n_rd, n_cs, n_wr);
        end
        tests++;
        if (blk_cnt !== 0 || busy !== 1'b0) begin
            fails++; $display("FAIL zero_end: cnt %0d busy %b expected 0 0", blk_cnt, busy);
        end
    endtask

    task automatic test_size40();
        int s;
        int exp_b[3] = '{16, 16, 8};
        run_msg(40, 4, 0, 0, -1, -1, s);
        tests++;
        if (obs_bytes.size() !== 3) begin
            fails++; $display("FAIL s40_blocks: got %0d expected 3", obs_bytes.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                tests++;
                if (obs_bytes[i] !== exp_b[i]) begin
                    fails++; $display("FAIL s40_bytes[%0d]: got %0d expected %0d", i, obs_bytes[i], exp_b[i]);
                end
            end
            tests++;
            if (obs_mask[2] !== 32'h00FF) begin
                fails++; $display("FAIL s40_last_mask: got %h expected 00ff", obs_mask[2]);
            end
        end
        tests++;
        if (n_nxt !== 3 || blk_cnt !== 3) begin
            fails++; $display("FAIL s40_counts: nxt %0d cnt %0d expected 3 3", n_nxt, blk_cnt);
        end
        tests++;
        if (n_done !== 1 || done_cyc - s !== 24) begin
            fails++; $display("FAIL s40_done: count %0d cycle %0d expected 1 24", n_done, done_cyc - s);
        end
    endtask

    task automatic test_din_stall();
        int s;
        run_msg(32, 4, 10, 0, -1, -1, s);
        tests++;
        if (first_rd - s !== 10) begin
            fails++; $display("FAIL din_stall_first_rd: got %0d expected 10", first_rd - s);
        end
        tests++;
        if (obs_bytes.size() !== 2 || obs_bytes[0] !== 16 || obs_bytes[1] !== 16 ||
            obs_mask[0] !== 32'hFFFF || obs_mask[1] !== 32'hFFFF) begin
            fails++; $display("FAIL din_stall_blocks: got %0d blocks expected 2 of 16 bytes mask ffff", obs_bytes.size());
        end
        tests++;
        if (n_done !== 1 || done_cyc - s !== ref_done_off(32, 4, 10, 0)) begin
            fails++; $display("FAIL din_stall_done: count %0d cycle %0d expected 1 %0d",
                              n_done, done_cyc - s, ref_done_off(32, 4, 10, 0));
        end
    endtask

    task automatic test_dout_stall();
        int s;
        run_msg(16, 4, 0, 5, -1, -1, s);
        tests++;
        if (first_wr - s !== 13) begin
            fails++; $display("FAIL dout_stall_first_wr: got %0d expected 13", first_wr - s);
        end
        tests++;
        if (n_wr !== 1 || n_nxt !== 1 || pair_err !== 0) begin
            fails++; $display("FAIL dout_stall_pulses: wr %0d nxt %0d pair_err %0d expected 1 1 0", n_wr, n_nxt, pair_err);
        end
        tests++;
        if (blk_bytes !== 5'd16 || n_done !== 1) begin
            fails++; $display("FAIL dout_stall_end: bytes %0d done %0d expected 16 1", blk_bytes, n_done);
        end
    endtask

    task automatic test_clr();
        int s;
        clear_mon();
        core_lat = 6;
        size_in  = 32'd64;
        s = cyc; start = 1'b1; din_vld = 1'b1; dout_rdy = 1'b1;
        step(1);
        start = 1'b0;
        step(13);                  // cycle s+14: second block is in RUN
        clr_core = 1'b1;
        #1;
        tests++;
        if (n_wr !== 1 || busy !== 1'b1) begin
            fails++; $display("FAIL clr_pre: wr %0d busy %b expected 1 1", n_wr, busy);
        end
        tests++;
        if ({done, remain_up, remain_nxt, din_rd, core_start, dout_wr} !== 6'b0) begin
            fails++; $display("FAIL clr_pulses: got %b expected 000000",
                              {done, remain_up, remain_nxt, din_rd, core_start, dout_wr});
        end
        step(1);
        clr_core = 1'b0;
        tests++;
        if (busy !== 1'b0 || blk_cnt !== 0) begin
            fails++; $display("FAIL clr_idle: busy %b cnt %0d expected 0 0", busy, blk_cnt);
        end
        step(6);                   // late core_done lands in this window
        tests++;
        if (busy !== 1'b0 || n_done !== 0 || n_rd !== 2) begin
            fails++; $display("FAIL clr_late_core: busy %b done %0d rd %0d expected 0 0 2", busy, n_done, n_rd);
        end
        // clr_core with start stays idle
        clr_core = 1'b1; start = 1'b1;
        step(1);
        clr_core = 1'b0; start = 1'b0;
        step(2);
        tests++;
        if (busy !== 1'b0 || n_up !== 1) begin
            fails++; $display("FAIL clr_with_start: busy %b up %0d expected 0 1", busy, n_up);
        end
        run_msg(1, 3, 0, 0, -1, -1, s);
        tests++;
        if (obs_bytes.size() !== 1 || obs_bytes[0] !== 1 || obs_mask[0] !== 32'h0001 || n_done !== 1) begin
            fails++; $display("FAIL clr_restart: blocks %0d bytes %0d done %0d expected 1 1 1",
                              obs_bytes.size(), blk_bytes, n_done);
        end
    endtask

    task automatic test_back_to_back();
        int s;
        int d0;
        run_msg(48, 3, 5, 0, -1, -1, s);
        d0 = done_cyc - s;
        run_msg(48, 3, 5, 0, 4, 8, s);
        tests++;
        if (done_cyc - s !== d0 || d0 !== ref_done_off(48, 3, 5, 0)) begin
            fails++; $display("FAIL b2b_done_cycle: got %0d undisturbed %0d expected %0d",
                              done_cyc - s, d0, ref_done_off(48, 3, 5, 0));
        end
        tests++;
        if (n_wr !== 3 || blk_cnt !== 3 || n_done !== 1 || n_up !== 1) begin
            fails++; $display("FAIL b2b_counts: wr %0d cnt %0d done %0d up %0d expected 3 3 1 1",
                              n_wr, blk_cnt, n_done, n_up);
        end
    endtask

    task automatic test_wrap();
        int s;
        run_msg(160, 1, 0, 0, -1, -1, s);
        tests++;
        if (blk_cnt !== CW'(10 % (1 << CW)) || n_wr !== 10) begin
            fails++; $display("FAIL wrap_cnt: cnt %0d wr %0d expected %0d 10", blk_cnt, n_wr, 10 % (1 << CW));
        end
    endtask

    task automatic test_reset_mid();
        int s;
        clear_mon();
        core_lat = 4; size_in = 32'd40;
        s = cyc; start = 1'b1; din_vld = 1'b1; dout_rdy = 1'b1;
        step(1);
        start = 1'b0;
        step(9);
        rst_n = 1'b0;
        #1;
        tests++;
        if (busy !== 1'b0 || blk_cnt !== 0 || blk_bytes !== 0 || blk_mask !== 0 || din_rd !== 1'b0) begin
            fails++; $display("FAIL reset_mid: busy %b cnt %0d bytes %0d mask %h rd %b expected all 0",
                              busy, blk_cnt, blk_bytes, blk_mask, din_rd);
        end
        din_vld = 1'b0; dout_rdy = 1'b0; core_due = -1;
        step(2);
        rst_n = 1'b1;
        step(2);
    endtask

    task automatic test_random();
        int s, size, lat, dh, oh, n;
        int fixed[3] = '{17, 15, 1};
        for (int it = 0; it < 20; it++) begin
            size = (it < 3) ? fixed[it] : int'($urandom_range(0, 200));
            lat  = int'($urandom_range(1, 6));
            dh   = int'($urandom_range(0, 6));
            oh   = int'($urandom_range(0, 3));
            n    = ref_blocks(size);
            run_msg(size, lat, dh, oh, -1, -1, s);
            tests++;
            if (n_done !== 1 || done_cyc - s !== ref_done_off(size, lat, dh, oh)) begin
                fails++; $display("FAIL rnd_done size=%0d: count %0d cycle %0d expected 1 %0d",
                                  size, n_done, done_cyc - s, ref_done_off(size, lat, dh, oh));
            end
            tests++;
            if (obs_bytes.size() !== n || blk_cnt !== CW'(n % (1 << CW)) || pair_err !== 0) begin
                fails++; $display("FAIL rnd_count size=%0d: blocks %0d cnt %0d pair_err %0d expected %0d %0d 0",
                                  size, obs_bytes.size(), blk_cnt, pair_err, n, n % (1 << CW));
            end else begin
                for (int i = 0; i < n; i++) begin
                    tests++;
                    if (obs_bytes[i] !== ref_bytes(size, i) || obs_mask[i] !== ref_mask(ref_bytes(size, i))) begin
                        fails++; $display("FAIL rnd_block size=%0d blk %0d: bytes %0d mask %h expected %0d %h",
                                          size, i, obs_bytes[i], obs_mask[i],
                                          ref_bytes(size, i), ref_mask(ref_bytes(size, i)));
                    end
                end
            end
        end
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_zero();
        test_size40();
        test_din_stall();
        test_dout_stall();
        test_clr();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/moo_blk_seq.md
# moo_blk_seq

Block sequencer for the mode-of-operation core. It loads the message length into the size buffer, then runs the message 16 bytes at a time: pull one input block, start the cipher engine, wait for the result, write the output block, and advance the remaining-size counter. It sits between the top-level command logic and the size buffer, input FIFO, cipher engine and output buffer, and signals completion once the remaining size reaches zero.

## Interface
Parameters:
- BLK_BYTES, 16, bytes per block. The size buffer decrements by this amount.
- CNT_W, 16, width of the processed-block counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- clr_core  in  1  synchronous abort/clear. Takes priority over all other inputs.
- start  in  1  one-cycle request to process a message. Size is already on the size buffer input.
- busy  out  1  high whenever the FSM is not in IDLE
- done  out  1  one-cycle pulse on normal completion
- remain_up  out  1  one-cycle pulse that loads the size buffer with the message size
- remain_nxt  out  1  one-cycle pulse that consumes one block in the size buffer
- remain_size  in  32  remaining bytes, from the size buffer
- msg_lst  in  1  remain_size < 17
- msg_done  in  1  remain_size == 0
- din_vld  in  1  input FIFO holds one full block
- din_rd  out  1  one-cycle pop of one input block
- core_start  out  1  one-cycle cipher engine start
- core_done  in  1  one-cycle cipher engine completion
- dout_rdy  in  1  output buffer can accept one block
- dout_wr  out  1  one-cycle write of one output block
- blk_bytes  out  5  valid bytes in the current block, range 1..16
- blk_mask  out  16  byte-valid mask; bit0 is the first byte
- blk_cnt  out  CNT_W  blocks completed since the last start

## Operation
States: IDLE, LOAD, CHK, WAIT_IN, RUN, WAIT_OUT, FIN.

- **IDLE:** On start, go to LOAD and clear blk_cnt. start received while busy is ignored.
- **LOAD:** Drive remain_up for one cycle, then go to CHK.
- **CHK:** The size buffer output is now updated. If msg_done, go to FIN; otherwise go to WAIT_IN.
- **WAIT_IN:** Wait for din_vld. On the cycle din_vld=1:
  - drive din_rd=1 and core_start=1;
  - latch blk_bytes = msg_lst ? remain_size[4:0] : 16;
  - go to RUN.
- **RUN:** Wait for core_done, then go to WAIT_OUT. core_done seen in any other state is ignored.
- **WAIT_OUT:** Wait for dout_rdy. On the cycle dout_rdy=1:
  - drive dout_wr=1 and remain_nxt=1;
  - increment blk_cnt, wrapping at 2^CNT_W-1 → 0;
  - go to CHK.
- **FIN:** Drive done=1 for one cycle, then go to IDLE.

blk_mask = (1<<blk_bytes)-1, so 16 gives 16'hFFFF. blk_bytes and blk_mask hold their value until the next WAIT_IN capture.

Size buffer model the bench uses:
- remain_up loads the size on the next edge.
- remain_nxt subtracts 16 on the next edge, or goes to 0 when msg_lst.
- msg_lst and msg_done are combinational from remain_size.

## Timing
- Reset values: FSM=IDLE; busy, done, remain_up, remain_nxt, din_rd, core_start and dout_wr all 0; blk_bytes=0, blk_mask=0, blk_cnt=0.
- All outputs are registered state decodes or Moore/Mealy pulses asserted for exactly one cycle. No pulse repeats while its handshake input stays high.
- start is sampled in cycle 0:
  - LOAD in cycle 1 (remain_up=1);
  - CHK in cycle 2;
  - earliest din_rd/core_start in cycle 3.
- Per-block cost with din_vld and dout_rdy held high is core latency + 3 cycles:
  - WAIT_IN: 1 cycle;
  - RUN: until core_done, with the transition on the core_done cycle;
  - WAIT_OUT: 1 cycle;
  - CHK: 1 cycle.
- done is asserted 1 cycle after the CHK that sees msg_done. busy drops in the cycle after done.
- clr_core, in any state:
  - next state is IDLE and blk_cnt=0;
  - no done pulse;
  - all pulse outputs are 0 in the clr_core cycle;
  - clr_core together with start stays in IDLE.
- rst_n asserted mid-operation: immediate return to reset values. The size buffer is reset independently.
- Zero-length message: start → LOAD → CHK → FIN. done in cycle 3; no din_rd, core_start or dout_wr ever pulses.

## Test plan
- **Size 0:** start with size=0 → remain_up in cycle 1, done in cycle 3; din_rd, core_start and dout_wr never pulse; blk_cnt=0.
- **Size 40, all ready, core latency 4:**
  - three blocks with blk_bytes 16, 16, 8;
  - last blk_mask=16'h00FF;
  - 3 remain_nxt pulses; blk_cnt=3; done once.
- **Size 32, din_vld held low 10 cycles:** the FSM stays in WAIT_IN with no din_rd. Then blocks 16 and 16 (blk_mask=16'hFFFF); done.
- **Size 16, dout_rdy low 5 cycles after core_done:** dout_wr and remain_nxt pulse together, exactly once, on the first dout_rdy cycle; blk_bytes=16; done.
- **clr_core during RUN of the 2nd block of a 64-byte message:** the next cycle is IDLE; busy=0; blk_cnt=0; no done; a late core_done is ignored; a new start of size 1 gives blk_bytes=1, blk_mask=16'h0001.
- **start pulsed while busy, plus a spurious core_done in WAIT_IN:** both are ignored; block count and done timing are identical to the undisturbed run.
